// File: rtl/glb_port_arbiter_if.sv
// Requester-side and SRAM-side bus of the global-buffer port arbiter.
// The arbiter takes the slave view; requesters plus the SRAM macro take the master view.
interface glb_port_arbiter_if #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ-1:0]            lock;
   logic [NUM_REQ-1:0]            we;
   logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rvalid;
   logic [DATA_WIDTH-1:0]         rdata;
   logic                          mem_en;
   logic                          mem_we;
   logic [ADDR_WIDTH-1:0]         mem_addr;
   logic [DATA_WIDTH-1:0]         mem_wdata;
   logic [DATA_WIDTH-1:0]         mem_rdata;

   modport master (
      output req, lock, we, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req, lock, we, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/glb_port_arbiter.sv
// Global-buffer SRAM port arbiter: round-robin with bounded burst locking,
// read data routed back to its requester through a fixed-latency tag pipeline.
module glb_port_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12,
   parameter int MEM_LAT    = 1,
   parameter int MAX_LOCK   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              halt,
   glb_port_arbiter_if.slave bus
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_LOCK) + 1;

   logic [IDX_W-1:0]              last_q, last_d;
   logic [IDX_W-1:0]              owner_q, owner_d;
   logic                          locked_q, locked_d;
   logic [CNT_W-1:0]              lock_cnt_q, lock_cnt_d;
   logic [MEM_LAT-1:0]            tag_valid_q, tag_valid_d;
   logic [MEM_LAT-1:0][IDX_W-1:0] tag_id_q, tag_id_d;

   logic               owner_req;
   logic               lock_hit;
   logic               lock_expired;
   logic [NUM_REQ-1:0] owner_mask;
   logic [NUM_REQ-1:0] cand;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic [IDX_W-1:0]   rr_idx;
   int                 rr_sum;

   always_comb begin
      owner_mask          = '0;
      owner_mask[owner_q] = 1'b1;
      owner_req           = locked_q && bus.req[owner_q];
      lock_hit            = owner_req && (lock_cnt_q < CNT_W'(MAX_LOCK));
      lock_expired        = owner_req && !lock_hit;
      cand                = bus.req;
      // An expired owner yields to anyone else waiting but keeps the port when alone.
      if (lock_expired && (|(bus.req & ~owner_mask))) begin
         cand = bus.req & ~owner_mask;
      end
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      rr_sum    = 0;
      rr_idx    = '0;
      if (lock_hit) begin
         gnt_valid = 1'b1;
         gnt_idx   = owner_q;
      end else begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = int'(last_q) + k;
            if (rr_sum >= NUM_REQ) begin
               rr_sum = rr_sum - NUM_REQ;
            end
            rr_idx = IDX_W'(rr_sum);
            if (!gnt_valid && cand[rr_idx]) begin
               gnt_valid = 1'b1;
               gnt_idx   = rr_idx;
            end
         end
      end
      if (halt || rst) begin
         gnt_valid = 1'b0;
         gnt_idx   = '0;
      end
   end

   always_comb begin
      bus.gnt       = '0;
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (gnt_valid) begin
         bus.gnt[gnt_idx] = 1'b1;
         bus.mem_en       = 1'b1;
         bus.mem_we       = bus.we[gnt_idx];
         bus.mem_addr     = bus.addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
         bus.mem_wdata    = bus.wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
      end
      bus.rvalid                        = '0;
      bus.rvalid[tag_id_q[MEM_LAT-1]]   = tag_valid_q[MEM_LAT-1];
   end

   assign bus.rdata = bus.mem_rdata;

   always_comb begin
      last_d     = last_q;
      owner_d    = owner_q;
      locked_d   = locked_q;
      lock_cnt_d = lock_cnt_q;
      if (halt) begin
         locked_d   = 1'b0;
         lock_cnt_d = '0;
      end else if (gnt_valid) begin
         last_d = gnt_idx;
         if (bus.lock[gnt_idx]) begin
            locked_d   = 1'b1;
            owner_d    = gnt_idx;
            lock_cnt_d = lock_hit ? (lock_cnt_q + CNT_W'(1)) : CNT_W'(1);
         end else begin
            locked_d   = 1'b0;
            lock_cnt_d = '0;
         end
      end else if (locked_q && !owner_req) begin
         locked_d   = 1'b0;
         lock_cnt_d = '0;
      end
   end

   // Stage 0 records who issued a read this cycle; the last stage lines up with mem_rdata.
   always_comb begin
      tag_valid_d    = '0;
      tag_id_d       = '0;
      tag_valid_d[0] = gnt_valid && !bus.we[gnt_idx];
      tag_id_d[0]    = tag_valid_d[0] ? gnt_idx : '0;
      for (int k = 1; k < MEM_LAT; k++) begin
         tag_valid_d[k] = tag_valid_q[k-1];
         tag_id_d[k]    = tag_id_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q      <= IDX_W'(NUM_REQ - 1);
         owner_q     <= '0;
         locked_q    <= 1'b0;
         lock_cnt_q  <= '0;
         tag_valid_q <= '0;
         tag_id_q    <= '0;
      end else begin
         last_q      <= last_d;
         owner_q     <= owner_d;
         locked_q    <= locked_d;
         lock_cnt_q  <= lock_cnt_d;
         tag_valid_q <= tag_valid_d;
         tag_id_q    <= tag_id_d;
      end
   end
endmodule

// File: tb/tb_glb_port_arbiter.sv
// Self-checking bench for glb_port_arbiter: vector table, directed corner sequences,
// then sticky random traffic against a rule-level reference model and an SRAM model.
module tb_glb_port_arbiter;
   localparam int NUM_REQ    = 3;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 12;
   localparam int MEM_LAT    = 1;
   localparam int MAX_LOCK   = 16;

   logic clk = 1'b0;
   logic rst;
   logic halt;

   glb_port_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   glb_port_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .MEM_LAT(MEM_LAT), .MAX_LOCK(MAX_LOCK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .halt(halt),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // SRAM model: unwritten words read back as a pattern derived from their address.
   bit [DATA_WIDTH-1:0] sram    [1<<ADDR_WIDTH];
   bit                  written [1<<ADDR_WIDTH];
   bit [DATA_WIDTH-1:0] sram_q  [MEM_LAT];

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) begin
         sram[bus.mem_addr]    <= bus.mem_wdata;
         written[bus.mem_addr] <= 1'b1;
      end
      if (bus.mem_en && !bus.mem_we) begin
         sram_q[0] <= written[bus.mem_addr] ? sram[bus.mem_addr] : (32'h5A00_0000 | 32'(bus.mem_addr));
      end else begin
         sram_q[0] <= '0;
      end
      for (int k = 1; k < MEM_LAT; k++) sram_q[k] <= sram_q[k-1];
   end

   assign bus.mem_rdata = sram_q[MEM_LAT-1];

   int checks;
   int errors;
   int cyc;

   logic [NUM_REQ-1:0]    cur_req, cur_lock, cur_we;
   logic [ADDR_WIDTH-1:0] drv_addr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] drv_wdata [NUM_REQ];

   logic [NUM_REQ-1:0]    obs_gnt, obs_rvalid;
   logic                  obs_en;
   logic [DATA_WIDTH-1:0] obs_rdata;

   // Reference model state, kept in plain integers.
   int  m_last, m_owner, m_cnt;
   bit  m_locked;
   typedef struct { int due; int id; logic [DATA_WIDTH-1:0] data; } rd_t;
   rd_t pend[$];
   logic [DATA_WIDTH-1:0] ref_mem [int];

   int                    exp_idx;
   logic [NUM_REQ-1:0]    exp_gnt, exp_rvalid;
   logic                  exp_en, exp_we;
   logic [ADDR_WIDTH-1:0] exp_addr;
   logic [DATA_WIDTH-1:0] exp_wdata, exp_rdata;

   typedef struct {
      logic [NUM_REQ-1:0] req;
      logic [NUM_REQ-1:0] lock;
      logic [NUM_REQ-1:0] we;
      logic               halt;
      logic [NUM_REQ-1:0] exp_gnt;
   } vec_t;
   vec_t vecs [19];

   function automatic logic [DATA_WIDTH-1:0] ref_read(input int a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 32'h5A00_0000 | 32'(a);
   endfunction

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_last   = NUM_REQ - 1;
      m_owner  = 0;
      m_cnt    = 0;
      m_locked = 1'b0;
      pend.delete();
   endtask

   task automatic model_eval();
      bit owner_wants;
      bit exclude;
      int c;
      exp_idx = -1;
      if (!rst && !halt) begin
         owner_wants = m_locked && cur_req[m_owner];
         if (owner_wants && m_cnt < MAX_LOCK) begin
            exp_idx = m_owner;
         end else begin
            exclude = owner_wants && ((cur_req & ~(NUM_REQ'(1) << m_owner)) != '0);
            for (int k = 1; k <= NUM_REQ; k++) begin
               c = (m_last + k) % NUM_REQ;
               if (exp_idx < 0 && cur_req[c] && !(exclude && c == m_owner)) exp_idx = c;
            end
         end
      end
      exp_gnt   = '0;
      exp_en    = 1'b0;
      exp_we    = 1'b0;
      exp_addr  = '0;
      exp_wdata = '0;
      if (exp_idx >= 0) begin
         exp_gnt[exp_idx] = 1'b1;
         exp_en           = 1'b1;
         exp_we           = cur_we[exp_idx];
         exp_addr         = drv_addr[exp_idx];
         exp_wdata        = drv_wdata[exp_idx];
      end
      exp_rvalid = '0;
      exp_rdata  = '0;
      if (!rst && pend.size() > 0 && pend[0].due == cyc) begin
         exp_rvalid[pend[0].id] = 1'b1;
         exp_rdata              = pend[0].data;
      end
   endtask

   task automatic model_commit();
      if (rst) begin
         model_reset();
      end else begin
         if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
         if (halt) begin
            m_locked = 1'b0;
            m_cnt    = 0;
         end else if (exp_idx >= 0) begin
            if (cur_we[exp_idx]) ref_mem[int'(drv_addr[exp_idx])] = drv_wdata[exp_idx];
            else pend.push_back('{cyc + MEM_LAT, exp_idx, ref_read(int'(drv_addr[exp_idx]))});
            if (cur_lock[exp_idx]) begin
               m_cnt    = (m_locked && m_owner == exp_idx && m_cnt < MAX_LOCK) ? m_cnt + 1 : 1;
               m_locked = 1'b1;
               m_owner  = exp_idx;
            end else begin
               m_locked = 1'b0;
               m_cnt    = 0;
            end
            m_last = exp_idx;
         end else if (m_locked && !cur_req[m_owner]) begin
            m_locked = 1'b0;
            m_cnt    = 0;
         end
      end
      cyc++;
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                                input logic [NUM_REQ-1:0] w, input logic h, input logic rs);
      cur_req  = r;
      cur_lock = l;
      cur_we   = w;
      halt     = h;
      rst      = rs;
      bus.req  = r;
      bus.lock = l;
      bus.we   = w;
      for (int i = 0; i < NUM_REQ; i++) begin
         bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = drv_addr[i];
         bus.wdata[i*DATA_WIDTH +: DATA_WIDTH] = drv_wdata[i];
      end
   endtask

   task automatic checkOutput();
      obs_gnt    = bus.gnt;
      obs_rvalid = bus.rvalid;
      obs_en     = bus.mem_en;
      obs_rdata  = bus.rdata;
      check_val("gnt", bus.gnt, exp_gnt);
      check_val("mem_en", bus.mem_en, exp_en);
      check_val("mem_we", bus.mem_we, exp_we);
      check_val("mem_addr", bus.mem_addr, exp_addr);
      check_val("mem_wdata", bus.mem_wdata, exp_wdata);
      check_val("rvalid", bus.rvalid, exp_rvalid);
      if (exp_rvalid != '0) check_val("rdata", bus.rdata, exp_rdata);
      else check_val("rdata_pass", bus.rdata, bus.mem_rdata);
   endtask

   task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] l,
                       input logic [NUM_REQ-1:0] w, input logic h, input logic rs);
      @(negedge clk);
      applyStimulus(r, l, w, h, rs);
      #1;
      model_eval();
      checkOutput();
      model_commit();
   endtask

   initial begin
      logic [NUM_REQ-1:0] rreq, rlock, bexp;
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      rst     = 1'b1;
      halt    = 1'b0;
      bus.req = '0;
      bus.lock = '0;
      bus.we  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         drv_addr[i]  = 12'h100 + 12'(i);
         drv_wdata[i] = 32'hD000_0000 | 32'(i);
      end
      model_reset();

      vecs[0]  = '{3'b111, 3'b000, 3'b000, 1'b0, 3'b001};
      vecs[1]  = '{3'b111, 3'b000, 3'b010, 1'b0, 3'b010};
      vecs[2]  = '{3'b111, 3'b000, 3'b000, 1'b0, 3'b100};
      vecs[3]  = '{3'b111, 3'b000, 3'b000, 1'b0, 3'b001};
      vecs[4]  = '{3'b110, 3'b000, 3'b000, 1'b0, 3'b010};
      vecs[5]  = '{3'b101, 3'b000, 3'b000, 1'b0, 3'b100};
      vecs[6]  = '{3'b011, 3'b000, 3'b001, 1'b0, 3'b001};
      vecs[7]  = '{3'b000, 3'b000, 3'b000, 1'b0, 3'b000};
      vecs[8]  = '{3'b100, 3'b000, 3'b000, 1'b1, 3'b000};
      vecs[9]  = '{3'b010, 3'b000, 3'b000, 1'b0, 3'b010};
      vecs[10] = '{3'b101, 3'b000, 3'b101, 1'b0, 3'b100};
      vecs[11] = '{3'b001, 3'b000, 3'b000, 1'b0, 3'b001};
      vecs[12] = '{3'b011, 3'b010, 3'b000, 1'b0, 3'b010};
      vecs[13] = '{3'b011, 3'b010, 3'b000, 1'b0, 3'b010};
      vecs[14] = '{3'b001, 3'b000, 3'b000, 1'b0, 3'b001};
      vecs[15] = '{3'b011, 3'b000, 3'b000, 1'b0, 3'b010};
      vecs[16] = '{3'b101, 3'b100, 3'b000, 1'b0, 3'b100};
      vecs[17] = '{3'b101, 3'b100, 3'b000, 1'b1, 3'b000};
      vecs[18] = '{3'b101, 3'b000, 3'b000, 1'b0, 3'b001};

      $display("[TB] reset");
      for (int n = 0; n < 2; n++) begin
         step(3'b111, 3'b000, 3'b000, 1'b0, 1'b1);
         check_val("rst_gnt", obs_gnt, '0);
         check_val("rst_rvalid", obs_rvalid, '0);
      end

      $display("[TB] vector table");
      for (int v = 0; v < 19; v++) begin
         step(vecs[v].req, vecs[v].lock, vecs[v].we, vecs[v].halt, 1'b0);
         check_val($sformatf("vec%0d_gnt", v), obs_gnt, vecs[v].exp_gnt);
      end

      $display("[TB] lock burst with competitors");
      for (int c = 0; c < 36; c++) begin
         step(3'b111, 3'b010, 3'b000, 1'b0, 1'b0);
         if (c < 16 || (c >= 18 && c < 34)) bexp = 3'b010;
         else if (c == 16 || c == 34) bexp = 3'b100;
         else bexp = 3'b001;
         check_val($sformatf("burst%0d_gnt", c), obs_gnt, bexp);
      end

      $display("[TB] lock expiry with a sole requester");
      for (int c = 0; c < 20; c++) begin
         step(3'b010, 3'b010, 3'b000, 1'b0, 1'b0);
         check_val($sformatf("alone%0d_gnt", c), obs_gnt, 3'b010);
      end
      for (int c = 0; c < 13; c++) begin
         step(3'b111, 3'b010, 3'b000, 1'b0, 1'b0);
         check_val($sformatf("restart%0d_gnt", c), obs_gnt, (c < 12) ? 3'b010 : 3'b100);
      end

      $display("[TB] halt with a read in flight");
      step(3'b011, 3'b000, 3'b000, 1'b0, 1'b0);
      check_val("pre_halt_gnt", obs_gnt, 3'b001);
      for (int h = 0; h < 5; h++) begin
         step(3'b011, 3'b000, 3'b000, 1'b1, 1'b0);
         check_val($sformatf("halt%0d_gnt", h), obs_gnt, '0);
         check_val($sformatf("halt%0d_en", h), obs_en, 1'b0);
         check_val($sformatf("halt%0d_rvalid", h), obs_rvalid, (h == 0) ? 3'b001 : 3'b000);
      end
      step(3'b011, 3'b000, 3'b000, 1'b0, 1'b0);
      check_val("post_halt0_gnt", obs_gnt, 3'b010);
      step(3'b011, 3'b000, 3'b000, 1'b0, 1'b0);
      check_val("post_halt1_gnt", obs_gnt, 3'b001);

      $display("[TB] reset mid-lock with a read in flight");
      step(3'b010, 3'b010, 3'b000, 1'b0, 1'b0);
      check_val("prerst_gnt", obs_gnt, 3'b010);
      for (int n = 0; n < 2; n++) begin
         step(3'b011, 3'b010, 3'b000, 1'b0, 1'b1);
         check_val($sformatf("midrst%0d_gnt", n), obs_gnt, '0);
         check_val($sformatf("midrst%0d_en", n), obs_en, 1'b0);
         check_val($sformatf("midrst%0d_rvalid", n), obs_rvalid, '0);
      end
      step(3'b111, 3'b000, 3'b000, 1'b0, 1'b0);
      check_val("postrst_gnt", obs_gnt, 3'b001);
      step(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
      check_val("postrst_rvalid", obs_rvalid, 3'b001);

      $display("[TB] back-to-back reads from requester 2");
      for (int n = 0; n < 4; n++) begin
         drv_addr[2] = 12'h010 + 12'(n);
         step((n < 3) ? 3'b100 : 3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
         check_val($sformatf("rd2_%0d_gnt", n), obs_gnt, (n < 3) ? 3'b100 : 3'b000);
         if (n > 0) begin
            check_val($sformatf("rd2_%0d_rvalid", n), obs_rvalid, 3'b100);
            check_val($sformatf("rd2_%0d_rdata", n), obs_rdata, 32'h5A00_000F + 32'(n));
         end
      end

      $display("[TB] random traffic");
      rreq  = '0;
      rlock = 3'b111;
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if ($urandom_range(0, 29) == 0) rreq[i] = ~rreq[i];
            drv_addr[i]  = 12'($urandom_range(0, 15));
            drv_wdata[i] = $urandom;
         end
         if ($urandom_range(0, 29) == 0) rlock = 3'($urandom_range(0, 7));
         step(rreq, rlock, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 499) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
